// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32I multicycle control path.
//   - FSM state codes (also exported on the debug `state` port)
//   - major opcodes the control unit accepts
//   - ALU operation codes driven on `alu_ctrl`
//   - datapath mux select codes (address, PC source, write-back, ALU operands)
//   - ctrl_t: bundle of every datapath strobe/select produced per cycle
package riscv_pkg;

  // FSM states
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  // Supported major opcodes
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // Memory address source
  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

  // PC write source
  localparam logic PC_ALU    = 1'b0;
  localparam logic PC_TARGET = 1'b1;

  // Register-file write-back source
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // ALU operand A source
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;

  // ALU operand B source
  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
  } ctrl_t;

  // True for the opcodes that DECODE lets through to EXEC.
  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/control_alu.sv
// control_alu: combinational ALU operation decode.
//   opcode, funct3, funct7 : decoder fields of the latched instruction
//   alu_ctrl               : ALU operation code for R/I arithmetic, SUB for
//                            branches, ADD for everything else
//   bad_funct              : funct7 value not valid for this R/I instruction
module control_alu
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl,
  output logic       bad_funct
);

  logic is_r;
  logic is_i;
  logic f7_std;

  assign is_r   = (opcode == OP_RTYPE);
  assign is_i   = (opcode == OP_ITYPE);
  // The only two funct7 patterns that base RV32I ever uses.
  assign f7_std = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

  always_comb begin
    alu_ctrl  = ALU_ADD;
    bad_funct = 1'b0;
    if (is_r || is_i) begin
      case (funct3)
        // ADDI has no subtract form; funct7 there is immediate bits.
        3'b000: alu_ctrl = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b001: alu_ctrl = ALU_SLL;
        3'b010: alu_ctrl = ALU_SLT;
        3'b011: alu_ctrl = ALU_SLTU;
        3'b100: alu_ctrl = ALU_XOR;
        3'b101: alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110: alu_ctrl = ALU_OR;
        3'b111: alu_ctrl = ALU_AND;
      endcase
      if (is_r) begin
        bad_funct = !f7_std;
      end else if (funct3 == 3'b001) begin
        // Immediate shifts: funct7 is part of the encoding, not the immediate.
        bad_funct = (funct7 != 7'b0000000);
      end else if (funct3 == 3'b101) begin
        bad_funct = !f7_std;
      end
    end else if (opcode == OP_BRANCH) begin
      alu_ctrl = ALU_SUB;
    end
  end

endmodule

// File: rtl/control_multiciclo.sv
// control_multiciclo: multicycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] over a shared datapath
// and owns the memory request handshake.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   opcode/funct3/funct7: decoder fields of the latched IR
//   zero                : ALU result is zero (branch compare)
//   mem_ready           : memory finishes the current request this cycle
//   mem_req/mem_we      : memory request / request is a store
//   addr_sel            : memory address source (PC or ALU result register)
//   ir_we, pc_we, pc_src: IR/old-PC latch, PC write and its source
//   reg_we, wb_sel      : register-file write and its data source
//   alu_a_sel/alu_b_sel : ALU operand selects
//   alu_ctrl            : ALU operation
//   state               : current FSM state (debug)
//   illegal             : sticky, set when an unsupported instruction is seen
module control_multiciclo
  import riscv_pkg::*;
#(
  parameter int ALU_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [2:0]       state,
  output logic             illegal
);

  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic       illegal_reg;
  ctrl_t      ctrl_next;
  ctrl_t      ctrl_out;
  logic [3:0] alu_next;
  logic [3:0] fn_alu;
  logic       fn_bad;

  control_alu u_control_alu (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .alu_ctrl  (fn_alu),
    .bad_funct (fn_bad)
  );

  always_comb begin
    state_next = state_reg;
    ctrl_next  = '0;
    alu_next   = ALU_ADD;
    case (state_reg)
      S_FETCH: begin
        // Request is held until memory answers; PC+4 is computed meanwhile
        // and committed together with the IR on the ready cycle.
        ctrl_next.mem_req   = 1'b1;
        ctrl_next.addr_sel  = ADDR_PC;
        ctrl_next.alu_a_sel = A_PC;
        ctrl_next.alu_b_sel = B_FOUR;
        if (mem_ready) begin
          ctrl_next.ir_we  = 1'b1;
          ctrl_next.pc_we  = 1'b1;
          ctrl_next.pc_src = PC_ALU;
          state_next       = S_DECODE;
        end
      end
      S_DECODE: begin
        // old-PC + imm: branch/JAL target, captured by the datapath.
        ctrl_next.alu_a_sel = A_OLDPC;
        ctrl_next.alu_b_sel = B_IMM;
        state_next = op_supported(opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE, OP_ITYPE: begin
            ctrl_next.alu_a_sel = A_RS1;
            ctrl_next.alu_b_sel = (opcode == OP_RTYPE) ? B_RS2 : B_IMM;
            alu_next   = fn_alu;
            state_next = fn_bad ? S_TRAP : S_WB;
          end
          OP_LOAD, OP_STORE: begin
            ctrl_next.alu_a_sel = A_RS1;
            ctrl_next.alu_b_sel = B_IMM;
            state_next = S_MEM;
          end
          OP_BRANCH: begin
            ctrl_next.alu_a_sel = A_RS1;
            ctrl_next.alu_b_sel = B_RS2;
            alu_next = ALU_SUB;
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
              // BEQ takes on zero, BNE on non-zero.
              ctrl_next.pc_we  = (funct3 == 3'b000) ? zero : !zero;
              ctrl_next.pc_src = PC_TARGET;
              state_next       = S_FETCH;
            end else begin
              state_next = S_TRAP;
            end
          end
          OP_JAL: begin
            ctrl_next.pc_we  = 1'b1;
            ctrl_next.pc_src = PC_TARGET;
            ctrl_next.reg_we = 1'b1;
            ctrl_next.wb_sel = WB_PC4;
            state_next       = S_FETCH;
          end
          default: state_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        ctrl_next.mem_req  = 1'b1;
        ctrl_next.addr_sel = ADDR_ALU;
        ctrl_next.mem_we   = (opcode == OP_STORE);
        if (mem_ready) begin
          state_next = (opcode == OP_STORE) ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        ctrl_next.reg_we = 1'b1;
        ctrl_next.wb_sel = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
        state_next       = S_FETCH;
      end
      S_TRAP: begin
        alu_next   = ALU_ADD;
        state_next = S_TRAP;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset silences every strobe immediately so a stalled request or a
  // half-executed instruction cannot commit anything in the reset cycle.
  always_comb begin
    ctrl_out = ctrl_next;
    if (reset) begin
      ctrl_out = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next == S_TRAP) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  assign mem_req   = ctrl_out.mem_req;
  assign mem_we    = ctrl_out.mem_we;
  assign addr_sel  = ctrl_out.addr_sel;
  assign ir_we     = ctrl_out.ir_we;
  assign pc_we     = ctrl_out.pc_we;
  assign pc_src    = ctrl_out.pc_src;
  assign reg_we    = ctrl_out.reg_we;
  assign wb_sel    = ctrl_out.wb_sel;
  assign alu_a_sel = ctrl_out.alu_a_sel;
  assign alu_b_sel = ctrl_out.alu_b_sel;
  assign alu_ctrl  = reset ? '0 : ALU_W'(alu_next);
  assign state     = state_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_control_multiciclo.sv
// Testbench for control_multiciclo: directed vector table, hand-written
// reset/abort sequences and randomized instructions checked against an
// instruction-level model (latency, strobe counts, write-back source).
module tb_control_multiciclo;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we;
  logic [1:0] wb_sel, alu_a_sel, alu_b_sel;
  logic [3:0] alu_ctrl;
  logic [2:0] state;
  logic       illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  control_multiciclo #(.ALU_W(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl),
    .state(state), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] ir;
    int          fw;
    int          mw;
    bit          z;
    bit          trap;
    int          cycles;
    int          reg_we_n;
    int          pc_we_n;
    int          mem_n;
    int          we_n;
    logic [1:0]  wb;
    logic [3:0]  alu;
    bit          chk_alu;
  } vec_t;

  typedef struct {
    int         cycles;
    int         reg_we_n;
    int         pc_we_n;
    int         ir_we_n;
    int         mem_n;
    int         we_n;
    int         hs_bad;
    logic [1:0] wb;
    logic [3:0] alu;
    bit         pc_src_exec;
    bit         done;
    bit         trap;
  } obs_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ir, input int fw, input int mw,
                              input bit z, input bit trap, input int cyc,
                              input int rw, input int pw, input int mn,
                              input int wn, input logic [1:0] wb,
                              input logic [3:0] alu, input bit ca);
    vec_t v;
    v.ir = ir; v.fw = fw; v.mw = mw; v.z = z; v.trap = trap; v.cycles = cyc;
    v.reg_we_n = rw; v.pc_we_n = pw; v.mem_n = mn; v.we_n = wn; v.wb = wb;
    v.alu = alu; v.chk_alu = ca;
    return v;
  endfunction

  // ALU code an arithmetic instruction must produce (R or I form).
  function automatic logic [3:0] alu_of(input bit is_r, input logic [2:0] f3,
                                        input logic [6:0] f7);
    int tbl[8];
    int r;
    tbl = '{0, 7, 5, 6, 4, 8, 3, 2};
    r = tbl[f3];
    if (f3 == 3'd0 && is_r && f7[5]) r = 1;
    if (f3 == 3'd5 && f7[5]) r = 9;
    return 4'(r);
  endfunction

  // Instruction-level reference: what one instruction should cost and do.
  function automatic vec_t model(input logic [31:0] ir, input int fw,
                                 input int mw, input bit z);
    vec_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit legal;
    op = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25];
    e = mk(ir, fw, mw, z, 0, 0, 0, 1, 0, 0, 2'd0, 4'd0, 0);
    legal = 1;
    case (op)
      7'h33: begin
        legal = (f7 == 7'h00 || f7 == 7'h20);
        e.cycles = fw + 4; e.reg_we_n = 1; e.chk_alu = 1; e.alu = alu_of(1, f3, f7);
      end
      7'h13: begin
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
        e.cycles = fw + 4; e.reg_we_n = 1; e.chk_alu = 1; e.alu = alu_of(0, f3, f7);
      end
      7'h03: begin
        e.cycles = fw + mw + 5; e.reg_we_n = 1; e.mem_n = mw + 1; e.wb = 2'b01;
      end
      7'h23: begin
        e.cycles = fw + mw + 4; e.mem_n = mw + 1; e.we_n = mw + 1;
      end
      7'h63: begin
        legal = (f3 == 3'd0 || f3 == 3'd1);
        e.cycles = fw + 3;
        e.pc_we_n = 1 + (((f3 == 3'd0) ? z : !z) ? 1 : 0);
      end
      7'h6F: begin
        e.cycles = fw + 3; e.reg_we_n = 1; e.pc_we_n = 2; e.wb = 2'b10;
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      e.trap = 1; e.reg_we_n = 0; e.pc_we_n = 1;
    end
    return e;
  endfunction

  // Plays memory and decoder for one instruction, starting in FETCH at
  // posedge+1; returns at posedge+1 once back in FETCH or in TRAP.
  task automatic run_instr(input logic [31:0] ir, input int fw, input int mw,
                           input bit z, output obs_t o);
    int waited;
    bit fetched, pend, fetch_now;
    logic [2:0] hs_prev;
    o.cycles = 0; o.reg_we_n = 0; o.pc_we_n = 0; o.ir_we_n = 0; o.mem_n = 0;
    o.we_n = 0; o.hs_bad = 0; o.wb = 2'd0; o.alu = 4'd0; o.pc_src_exec = 0;
    o.done = 0; o.trap = 0;
    waited = 0; fetched = 0; pend = 0; hs_prev = 3'd0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      zero = z;
      if (fetched) begin
        opcode = ir[6:0]; funct3 = ir[14:12]; funct7 = ir[31:25];
      end else begin
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      end
      mem_ready = 1'b0;
      #1;
      if (mem_req) mem_ready = (waited >= (fetched ? mw : fw));
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      o.cycles++;
      if (pend && {mem_req, mem_we, addr_sel} != hs_prev) o.hs_bad++;
      if (mem_we && !mem_req) o.hs_bad++;
      if (ir_we) o.ir_we_n++;
      if (pc_we) begin
        o.pc_we_n++;
        if (state == 3'd2) o.pc_src_exec = pc_src;
        else if (pc_src) o.hs_bad++;
      end
      if (reg_we) begin o.reg_we_n++; o.wb = wb_sel; end
      if (state == 3'd2) o.alu = alu_ctrl;
      if (mem_req && addr_sel) o.mem_n++;
      if (mem_we) o.we_n++;
      fetch_now = 0;
      if (mem_req && mem_ready) begin
        waited = 0;
        if (!fetched) fetch_now = 1;
      end else if (mem_req) begin
        waited++;
      end
      pend = mem_req && !mem_ready;
      hs_prev = {mem_req, mem_we, addr_sel};
      @(posedge clock); #1;
      if (fetch_now) fetched = 1;
      if (state == 3'd5) begin o.trap = 1; break; end
      if (state == 3'd0 && fetched) begin o.done = 1; break; end
    end
  endtask

  // Reset pulse from posedge+1; strobes and selects must be silent during it.
  task automatic do_reset(input string nm);
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1;
    opcode = 7'h6F; funct3 = 3'd0; funct7 = 7'd0;
    @(negedge clock);
    chk({nm, "/rst_strobes"}, int'({mem_req, mem_we, ir_we, pc_we, reg_we}), 0);
    chk({nm, "/rst_selects"}, int'({addr_sel, pc_src, wb_sel, alu_a_sel, alu_b_sel}), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk({nm, "/rst_state"}, int'(state), 0);
    chk({nm, "/rst_illegal"}, int'(illegal), 0);
  endtask

  task automatic apply(input string nm, input vec_t v);
    obs_t o;
    run_instr(v.ir, v.fw, v.mw, v.z, o);
    $display("instr %s ir=%08h fw=%0d mw=%0d z=%0d cycles=%0d trap=%0d",
             nm, v.ir, v.fw, v.mw, v.z, o.cycles, o.trap);
    chk({nm, "/ended"}, int'(o.done || o.trap), 1);
    chk({nm, "/trap"}, int'(o.trap), int'(v.trap));
    chk({nm, "/reg_we_n"}, o.reg_we_n, v.reg_we_n);
    chk({nm, "/pc_we_n"}, o.pc_we_n, v.pc_we_n);
    chk({nm, "/ir_we_n"}, o.ir_we_n, 1);
    chk({nm, "/handshake"}, o.hs_bad, 0);
    if (!v.trap) begin
      chk({nm, "/cycles"}, o.cycles, v.cycles);
      chk({nm, "/mem_cycles"}, o.mem_n, v.mem_n);
      chk({nm, "/we_cycles"}, o.we_n, v.we_n);
      if (v.reg_we_n > 0) chk({nm, "/wb_sel"}, int'(o.wb), int'(v.wb));
      if (v.chk_alu) chk({nm, "/alu_ctrl"}, int'(o.alu), int'(v.alu));
      if (v.pc_we_n > 1) chk({nm, "/pc_src"}, int'(o.pc_src_exec), 1);
    end
    if (o.trap) begin
      // TRAP is sticky and silent regardless of inputs.
      for (int k = 0; k < 2; k++) begin
        mem_ready = 1'b1;
        @(negedge clock);
        chk({nm, "/trap_illegal"}, int'(illegal), 1);
        chk({nm, "/trap_strobes"}, int'({mem_req, mem_we, ir_we, pc_we, reg_we}), 0);
        @(posedge clock); #1;
        chk({nm, "/trap_state"}, int'(state), 5);
      end
      do_reset(nm);
    end else if (!o.done) begin
      do_reset({nm, "/recover"});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    logic [6:0] bad_ops[5];
    tbl[0]  = mk(32'h00208033, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 4'd0, 1); // ADD
    tbl[1]  = mk(32'h00012083, 0, 3, 0, 0, 8, 1, 1, 4, 0, 2'b01, 4'd0, 0); // LW, 3 waits
    tbl[2]  = mk(32'h00208463, 0, 0, 1, 0, 3, 0, 2, 0, 0, 2'b00, 4'd0, 0); // BEQ taken
    tbl[3]  = mk(32'h00208463, 0, 0, 0, 0, 3, 0, 1, 0, 0, 2'b00, 4'd0, 0); // BEQ not taken
    tbl[4]  = mk(32'h4020d093, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 4'd9, 1); // SRAI
    tbl[5]  = mk(32'h2020d093, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0, 0); // SRAI bad funct7
    tbl[6]  = mk(32'h0000007f, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0, 0); // bad opcode
    tbl[7]  = mk(32'h008000ef, 2, 0, 0, 0, 5, 1, 2, 0, 0, 2'b10, 4'd0, 0); // JAL, fetch wait 2
    tbl[8]  = mk(32'h00112223, 1, 2, 0, 0, 7, 0, 1, 3, 3, 2'b00, 4'd0, 0); // SW
    tbl[9]  = mk(32'h40208033, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 4'd1, 1); // SUB
    tbl[10] = mk(32'h00209463, 0, 0, 0, 0, 3, 0, 2, 0, 0, 2'b00, 4'd0, 0); // BNE taken
    tbl[11] = mk(32'h02208033, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0, 0); // MUL: trap
    tbl[12] = mk(32'h0010b093, 1, 0, 0, 0, 5, 1, 1, 0, 0, 2'b00, 4'd6, 1); // SLTIU
    tbl[13] = mk(32'h40109093, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0, 0); // SLLI bad funct7
    tbl[14] = mk(32'h0020c463, 0, 0, 1, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0, 0); // BLT: trap
    bad_ops = '{7'h37, 7'h17, 7'h67, 7'h7F, 7'h0F};

    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    @(posedge clock); #1;
    do_reset("init");

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Reset while a fetch is stalled: request drops, nothing is committed.
    for (int k = 0; k < 2; k++) begin
      mem_ready = 1'b0;
      @(negedge clock);
      chk("stall/mem_req", int'(mem_req), 1);
      chk("stall/ir_pc_we", int'({ir_we, pc_we}), 0);
      @(posedge clock); #1;
    end
    reset = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("stallrst/mem_req", int'(mem_req), 0);
      chk("stallrst/ir_pc_we", int'({ir_we, pc_we}), 0);
      @(posedge clock); #1;
    end
    reset = 1'b0; mem_ready = 1'b0;
    chk("stallrst/state", int'(state), 0);
    @(negedge clock);
    chk("stallrst/new_req", int'(mem_req), 1);
    @(posedge clock); #1;
    $display("seq reset_during_fetch_stall done");
    apply("after_stall", tbl[0]);

    // Reset in the EXEC cycle of a JAL: no PC or register write.
    mem_ready = 1'b1;
    @(posedge clock); #1;
    opcode = 7'h6F; funct3 = 3'd0; funct7 = 7'd0; mem_ready = 1'b0;
    @(posedge clock); #1;
    chk("jalrst/in_exec", int'(state), 2);
    reset = 1'b1;
    @(negedge clock);
    chk("jalrst/pc_reg_we", int'({pc_we, reg_we}), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("jalrst/state", int'(state), 0);
    $display("seq reset_during_jal_exec done");

    // Randomized instructions against the model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ir;
      int k;
      ir = $urandom;
      k = $urandom_range(0, 9);
      case (k)
        0, 1: begin
          ir[6:0] = 7'h33;
          case ($urandom_range(0, 3))
            0: ir[31:25] = 7'h00;
            1: ir[31:25] = 7'h20;
            2: ir[31:25] = 7'h00;
            default: ;
          endcase
        end
        2, 3: begin
          ir[6:0] = 7'h13;
          if ($urandom_range(0, 1) == 1) ir[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        4: ir[6:0] = 7'h03;
        5: ir[6:0] = 7'h23;
        6: begin
          ir[6:0] = 7'h63;
          if ($urandom_range(0, 3) != 0) ir[14:12] = 3'($urandom_range(0, 1));
        end
        7: ir[6:0] = 7'h6F;
        8: ir[6:0] = bad_ops[$urandom_range(0, 4)];
        default: ;
      endcase
      apply($sformatf("rnd%0d", n),
            model(ir, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1))));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multicycle control unit for the RV32I core. Sequences fetch, decode, execute, memory and write-back over the shared datapath: PC, IR, register file, single ALU and one memory port. It consumes the opcode/funct3/funct7 fields produced by `Decodificador` from the latched IR and drives every datapath enable and mux select. It also owns the memory request handshake.

## Interface
- `ALU_W`, 4, width of `alu_ctrl`
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  7  from decoder (latched IR)
- `funct3`  in  3  from decoder
- `funct7`  in  7  from decoder
- `zero`  in  1  ALU result == 0
- `mem_ready`  in  1  memory completes current request this cycle
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  request is a store
- `addr_sel`  out  1  0 = PC, 1 = ALU result register
- `ir_we`  out  1  latch IR and old-PC
- `pc_we`  out  1  write PC
- `pc_src`  out  1  0 = ALU output, 1 = target register
- `reg_we`  out  1  register-file write
- `wb_sel`  out  2  00 ALU, 01 memory data, 10 old-PC+4
- `alu_a_sel`  out  2  00 PC, 01 old-PC, 10 rs1
- `alu_b_sel`  out  2  00 rs2, 01 immediate, 10 constant 4
- `alu_ctrl`  out  ALU_W  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLTU=6 SLL=7 SRL=8 SRA=9
- `state`  out  3  current state, for debug
- `illegal`  out  1  sticky, unsupported instruction seen

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- **FETCH**
  - `mem_req`=1, `addr_sel`=0, ALU = PC + 4.
  - Hold state until `mem_ready`.
  - On the ready cycle: `ir_we`=1, `pc_we`=1 with `pc_src`=0, then go to DECODE.
- **DECODE**
  - ALU = old-PC + imm (branch/JAL target, latched by datapath).
  - Next state: EXEC for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111.
  - Any other opcode goes to TRAP.
- **EXEC, R-type (0110011)**
  - ALU rs1 op rs2, then go to WB.
  - `alu_ctrl` from funct3 and funct7[5].
  - funct7 other than 0000000/0100000 goes to TRAP.
- **EXEC, I-type (0010011)**
  - ALU rs1 op imm, then go to WB.
  - funct7[5] is honoured only for shifts (funct3 101).
  - funct3 001/101 with illegal funct7 goes to TRAP.
- **EXEC, load/store**
  - ALU = rs1 + imm, then go to MEM.
- **EXEC, branch**
  - ALU SUB rs1, rs2.
  - funct3 000: `pc_we` = `zero`. funct3 001: `pc_we` = !`zero`. `pc_src`=1.
  - Then go to FETCH. Other funct3 goes to TRAP with no `pc_we`.
- **EXEC, JAL**
  - `pc_we`=1 with `pc_src`=1, and `reg_we`=1 with `wb_sel`=10, in the same cycle. Then go to FETCH.
- **MEM**
  - `mem_req`=1, `addr_sel`=1, `mem_we`=1 for stores. Hold until `mem_ready`.
  - Load: go to WB. Store: go to FETCH.
- **WB**
  - `reg_we`=1. `wb_sel`=01 for loads, 00 otherwise. Then go to FETCH.
- **TRAP**
  - All strobes 0, `illegal`=1. Remain there until `reset`.

## Timing
- Reset: state=FETCH, `illegal`=0. All strobes (`mem_req`, `mem_we`, `ir_we`, `pc_we`, `reg_we`) are 0 in the reset cycle; selects are 0.
- Outputs are combinational from registered state, registered IR fields and `mem_ready`. Only `illegal` is a register.
- Latency in cycles with zero-wait memory: branch/JAL 3, R/I/store 4, load 5. Each wait cycle adds 1.
- Handshake rules:
  - `mem_req`, `mem_we` and `addr_sel` stay stable from assertion until the cycle `mem_ready`=1.
  - `mem_ready` while `mem_req`=0 is ignored.
  - `ir_we` and `pc_we` in FETCH assert only in the ready cycle.
- `reset` mid-operation, including during a stalled request: next cycle is FETCH with `mem_req` dropped. No `reg_we`/`pc_we` for the aborted instruction.
- Decoder inputs are sampled only in DECODE, EXEC, MEM and WB. In FETCH they are don't-care.

## Structure
- Shared package `riscv_pkg`: state encodings, opcode constants, `alu_ctrl` codes, `wb_sel`/`alu_a_sel`/`alu_b_sel` codes.
- One sub-module `control_alu`: combinational funct3/funct7/opcode to `alu_ctrl` plus a `bad_funct` flag. The FSM forces ADD/SUB outside R/I EXEC.

## Test plan
- Reset then R-type ADD 0x00208033, `mem_ready` always 1: states 0,1,2,4,0. `alu_ctrl`=0 in EXEC, `reg_we`=1 exactly once, `wb_sel`=00.
- Load 0x00012083 with 3 wait cycles in MEM: `mem_req`=1, `addr_sel`=1 held 4 cycles. Then WB with `wb_sel`=01. Total 8 cycles.
- BEQ 0x00208463:
  - `zero`=1: `pc_we`=1, `pc_src`=1 in EXEC.
  - `zero`=0: no `pc_we` in EXEC.
  - Both cases return to FETCH after 3 cycles.
- SRAI 0x4020d093: `alu_ctrl`=9. With funct7=0x10: TRAP, `illegal`=1, no `reg_we`.
- Opcode 0x7F: TRAP after DECODE, `illegal` sticky. `reset` pulse returns to FETCH with `illegal`=0.
- `reset` asserted in FETCH with `mem_ready`=0 for 2 cycles: `mem_req` drops next cycle, no `ir_we`/`pc_we` emitted.
